// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one float adder and one float multiplier.
// The operation is issued through a registered issue stage and a fixed-depth result pipe.
// A single response port with backpressure returns the results.
// Number format: unsigned, {exponent, mantissa}. An exponent of 0 means zero.
// An overflowing result saturates to {all-ones exponent, zero mantissa}.

module flt_add #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] a,
    input  logic [EXP_W+MAN_W-1:0] b,
    output logic [EXP_W+MAN_W-1:0] y
);
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic [EXP_W-1:0] ea, eb, eh, el, d;
    logic [MAN_W:0]   mh, ml, ms;
    logic [MAN_W+1:0] sum;
    logic [EXP_W:0]   er;
    logic [MAN_W-1:0] mr;

    // Align the smaller operand, add the significands, and renormalise by at most one place
    always_comb begin
        ea = a[EXP_W+MAN_W-1:MAN_W];
        eb = b[EXP_W+MAN_W-1:MAN_W];
        if (ea >= eb) begin
            eh = ea;
            mh = {1'b1, a[MAN_W-1:0]};
            el = eb;
            ml = {1'b1, b[MAN_W-1:0]};
        end else begin
            eh = eb;
            mh = {1'b1, b[MAN_W-1:0]};
            el = ea;
            ml = {1'b1, a[MAN_W-1:0]};
        end
        d   = eh - el;
        ms  = ml >> d;
        sum = {1'b0, mh} + {1'b0, ms};
        if (sum[MAN_W+1]) begin
            er = {1'b0, eh} + 1'b1;
            mr = sum[MAN_W:1];
        end else begin
            er = {1'b0, eh};
            mr = sum[MAN_W-1:0];
        end
        if (ea == '0 && eb == '0)
            y = '0;
        else if (ea == '0)
            y = b;
        else if (eb == '0)
            y = a;
        else if (er >= EXP_MAX)
            y = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            y = {er[EXP_W-1:0], mr};
    end
endmodule

module flt_mul #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] a,
    input  logic [EXP_W+MAN_W-1:0] b,
    output logic [EXP_W+MAN_W-1:0] y
);
    localparam logic [EXP_W:0] BIAS    = {2'b00, {(EXP_W-1){1'b1}}};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic [EXP_W-1:0]   ea, eb;
    logic [2*MAN_W+1:0] prod;
    logic               adj;
    logic [MAN_W-1:0]   mr;
    logic [EXP_W:0]     esum, er;

    // Multiply the significands, normalise by one place, and rebias the exponent
    always_comb begin
        ea   = a[EXP_W+MAN_W-1:MAN_W];
        eb   = b[EXP_W+MAN_W-1:MAN_W];
        prod = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]} * {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
        adj  = prod[2*MAN_W+1];
        if (adj)
            mr = prod[2*MAN_W:MAN_W+1];
        else
            mr = prod[2*MAN_W-1:MAN_W];
        esum = {1'b0, ea} + {1'b0, eb} + {{EXP_W{1'b0}}, adj};
        er   = esum - BIAS;
        if (ea == '0 || eb == '0 || esum <= BIAS)
            y = '0;
        else if (er >= EXP_MAX)
            y = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            y = {er[EXP_W-1:0], mr};
    end
endmodule

module fp_unit_arbiter #(
    parameter int N_REQ      = 4,
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0]                    req_op,
    input  logic [N_REQ-1:0][EXP_W+MAN_W-1:0]   req_a,
    input  logic [N_REQ-1:0][EXP_W+MAN_W-1:0]   req_b,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [$clog2(N_REQ)-1:0]            rsp_id,
    output logic [EXP_W+MAN_W-1:0]              rsp_data,
    output logic [$clog2(PIPE_DEPTH+2)-1:0]     in_flight
);
    localparam int W   = EXP_W + MAN_W;
    localparam int IDW = $clog2(N_REQ);
    localparam int IFW = $clog2(PIPE_DEPTH+2);

    logic [IDW-1:0] ptr, ptr_next, gnt_idx;
    logic           gnt_found, accept, stall, rsp_hs;
    int unsigned    cand;

    logic           iss_valid, iss_op;
    logic [IDW-1:0] iss_id;
    logic [W-1:0]   iss_a, iss_b, add_y, mul_y, alu_y;

    logic [PIPE_DEPTH-1:0] pv;
    logic [IDW-1:0]        pid   [PIPE_DEPTH];
    logic [W-1:0]          pdata [PIPE_DEPTH];

    assign rsp_valid = pv[PIPE_DEPTH-1];
    assign rsp_id    = pid[PIPE_DEPTH-1];
    assign rsp_data  = pdata[PIPE_DEPTH-1];
    assign stall     = rsp_valid && !rsp_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign accept    = gnt_found && !stall && rst;

    // Round-robin search: first valid requester at or after ptr, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            if (!gnt_found && req_valid[IDW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
        ptr_next = (gnt_idx == IDW'(N_REQ-1)) ? '0 : gnt_idx + IDW'(1);
    end

    // One-hot ready toward the granted requester only when the accept can happen
    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[gnt_idx] = 1'b1;
    end

    // Issue register and rotation pointer; both freeze while the response port stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr       <= '0;
            iss_valid <= 1'b0;
            iss_id    <= '0;
            iss_op    <= 1'b0;
            iss_a     <= '0;
            iss_b     <= '0;
        end else if (!stall) begin
            iss_valid <= accept;
            if (accept) begin
                ptr    <= ptr_next;
                iss_id <= gnt_idx;
                iss_op <= req_op[gnt_idx];
                iss_a  <= req_a[gnt_idx];
                iss_b  <= req_b[gnt_idx];
            end
        end
    end

    flt_add #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_add (.a(iss_a), .b(iss_b), .y(add_y));
    flt_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (.a(iss_a), .b(iss_b), .y(mul_y));

    assign alu_y = iss_op ? mul_y : add_y;

    // Result pipe: shifts every unstalled cycle, bubbles included, holds whole while stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            pv <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pid[i]   <= '0;
                pdata[i] <= '0;
            end
        end else if (!stall) begin
            pv[0]    <= iss_valid;
            pid[0]   <= iss_id;
            pdata[0] <= alu_y;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                pv[i]    <= pv[i-1];
                pid[i]   <= pid[i-1];
                pdata[i] <= pdata[i-1];
            end
        end
    end

    // Occupancy of issue register plus pipe: up on accept, down on response handshake
    always_ff @(posedge clk) begin
        if (!rst)
            in_flight <= '0;
        else if (accept && !rsp_hs)
            in_flight <= in_flight + IFW'(1);
        else if (!accept && rsp_hs)
            in_flight <= in_flight - IFW'(1);
    end
endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter: single ops, rotation, backpressure, reset, streaming.
module tb_fp_unit_arbiter;
    logic             clk;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0]       req_op;
    logic [3:0][30:0] req_a;
    logic [3:0][30:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [30:0]      rsp_data;
    logic [1:0]       in_flight;

    int checks = 0;
    int errors = 0;

    fp_unit_arbiter #(.N_REQ(4), .EXP_W(8), .MAN_W(23), .PIPE_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .in_flight(in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: accept now, response exactly three cycles later
    task automatic single_op(input string tag, input int unsigned id, input logic op,
                             input logic [30:0] a, input logic [30:0] b, input logic [30:0] y);
        logic [3:0] exp_rdy;
        exp_rdy     = '0;
        exp_rdy[id] = 1'b1;
        req_valid     = '0;
        req_valid[id] = 1'b1;
        req_op[id]    = op;
        req_a[id]     = a;
        req_b[id]     = b;
        #1;
        check({tag, "_ready"}, req_ready, exp_rdy);
        tick();
        req_valid = '0;
        check({tag, "_c1_valid"}, rsp_valid, 0);
        check({tag, "_c1_inflight"}, in_flight, 1);
        tick();
        check({tag, "_c2_valid"}, rsp_valid, 0);
        check({tag, "_c2_inflight"}, in_flight, 1);
        tick();
        check({tag, "_c3_valid"}, rsp_valid, 1);
        check({tag, "_c3_id"}, rsp_id, id);
        check({tag, "_c3_data"}, rsp_data, y);
        check({tag, "_c3_inflight"}, in_flight, 1);
        tick();
        check({tag, "_c4_valid"}, rsp_valid, 0);
        check({tag, "_c4_inflight"}, in_flight, 0);
    endtask

    logic [30:0] rr_data [4];
    logic [1:0]  rr_ids  [4];
    logic [3:0]  exp_rdy;
    int          grant_n, resp_n;
    logic        stalled;

    initial begin
        // 2.0 * {1.0, 1.5, 2.0, 3.0}
        rr_data[0] = 31'h40000000;
        rr_data[1] = 31'h40400000;
        rr_data[2] = 31'h40800000;
        rr_data[3] = 31'h40C00000;

        rst = 1'b0; req_valid = 4'hF; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_inflight", in_flight, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst = 1'b1;
        tick();

        single_op("add_1p1", 2, 1'b0, 31'h3F800000, 31'h3F800000, 31'h40000000);
        single_op("mul_2x3", 0, 1'b1, 31'h40000000, 31'h40400000, 31'h40C00000);
        single_op("mul_zero", 0, 1'b1, 31'h40000000, 31'h00000000, 31'h00000000);
        single_op("add_2p1", 1, 1'b0, 31'h40000000, 31'h3F800000, 31'h40400000);
        single_op("mul_1p5sq", 3, 1'b1, 31'h3FC00000, 31'h3FC00000, 31'h40100000);

        // Rotation with all requesters valid; ptr is back at 0 after requester 3
        for (int i = 0; i < 4; i++) begin
            req_op[i] = 1'b1;
            req_a[i]  = 31'h40000000;
        end
        req_b[0] = 31'h3F800000;
        req_b[1] = 31'h3FC00000;
        req_b[2] = 31'h40000000;
        req_b[3] = 31'h40400000;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            exp_rdy = '0;
            if (k < 8) exp_rdy[2'(k % 4)] = 1'b1;
            check("rr_ready", req_ready, exp_rdy);
            check("rr_valid", rsp_valid, (k >= 3 && k < 11));
            check("rr_inflight", in_flight, (k < 3) ? k : (k < 9) ? 3 : 11 - k);
            if (k >= 3 && k < 11) begin
                check("rr_id", rsp_id, (k - 3) % 4);
                check("rr_data", rsp_data, rr_data[(k - 3) % 4]);
            end
            tick();
        end

        // Only requesters 1 and 3 valid: grants alternate
        rr_ids[0] = 2'd1; rr_ids[1] = 2'd3; rr_ids[2] = 2'd1; rr_ids[3] = 2'd3;
        for (int k = 0; k < 8; k++) begin
            req_valid = (k < 4) ? 4'b1010 : 4'b0000;
            #1;
            exp_rdy = '0;
            if (k < 4) exp_rdy[rr_ids[k]] = 1'b1;
            check("alt_ready", req_ready, exp_rdy);
            check("alt_valid", rsp_valid, (k >= 3 && k < 7));
            if (k >= 3 && k < 7) begin
                check("alt_id", rsp_id, rr_ids[k - 3]);
                check("alt_data", rsp_data, rr_data[rr_ids[k - 3]]);
            end
            tick();
        end

        // Backpressure: rsp_ready low in cycles 10..13 of continuous traffic
        grant_n = 0;
        resp_n  = 0;
        for (int k = 0; k < 20; k++) begin
            stalled   = (k >= 10 && k <= 13);
            req_valid = 4'hF;
            rsp_ready = !stalled;
            #1;
            exp_rdy = '0;
            if (!stalled) exp_rdy[2'(grant_n % 4)] = 1'b1;
            check("bp_ready", req_ready, exp_rdy);
            check("bp_valid", rsp_valid, k >= 3);
            if (stalled) begin
                check("bp_frozen_id", rsp_id, 3);
                check("bp_frozen_data", rsp_data, 31'h40C00000);
                check("bp_inflight", in_flight, 3);
            end
            if (rsp_valid && rsp_ready) begin
                check("bp_order_id", rsp_id, resp_n % 4);
                check("bp_order_data", rsp_data, rr_data[resp_n % 4]);
                resp_n++;
            end
            if (!stalled) grant_n++;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (rsp_valid) begin
                check("bp_drain_id", rsp_id, resp_n % 4);
                check("bp_drain_data", rsp_data, rr_data[resp_n % 4]);
                resp_n++;
            end
            tick();
        end
        check("bp_total_responses", resp_n, 16);
        check("bp_drain_inflight", in_flight, 0);

        // Reset with three ops in flight from requester 2 (ptr left at 3)
        req_op[2] = 1'b0;
        req_a[2]  = 31'h3F800000;
        req_b[2]  = 31'h3F800000;
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0100;
            #1;
            check("rsti_ready", req_ready, 4'b0100);
            tick();
        end
        req_valid = '0;
        #1;
        check("rsti_inflight", in_flight, 3);
        check("rsti_valid", rsp_valid, 1);
        check("rsti_id", rsp_id, 2);
        rst = 1'b0;
        req_valid = 4'hF;
        #1;
        check("rsti_ready_in_reset", req_ready, 0);
        tick();
        rst = 1'b1;
        #1;
        check("rsto_valid", rsp_valid, 0);
        check("rsto_inflight", in_flight, 0);
        check("rsto_id", rsp_id, 0);
        check("rsto_data", rsp_data, 0);
        check("rsto_ready_lowest", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("rsto_c1_valid", rsp_valid, 0);
        tick();
        check("rsto_c2_valid", rsp_valid, 0);
        tick();
        check("rsto_c3_valid", rsp_valid, 1);
        check("rsto_c3_id", rsp_id, 0);
        check("rsto_c3_data", rsp_data, 31'h40000000);
        tick();
        check("rsto_c4_valid", rsp_valid, 0);
        check("rsto_c4_inflight", in_flight, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
